regfile_wb: RTL and testbench

Architectural general-purpose register file of the five-stage pipeline. It is the consumer of the write-back interface (`wb_wd` / `wb_wreg` / `wb_wdata`) driven by the MEM/WB pipeline register. It serves the two operand read ports used by the ID stage and one debug read port. It also keeps a counter of committed register writes for bring-up and performance checks.

---
 rtl/regfile_wb_pkg.sv | 13 +
 rtl/regfile_rd_port.sv | 34 +++
 rtl/regfile_wb.sv | 51 +++++
 tb/tb_regfile_wb.sv | 123 ++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared register-file defines (reset/enable levels, bus widths, null values)
package regfile_wb_pkg;
  localparam int REG_BUS = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int REG_NUM = 32;
  localparam logic RST_ENABLE = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE = 1'b1;
  localparam logic READ_DISABLE = 1'b0;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
  localparam logic [REG_ADDR_BUS-1:0] NOP_REG_ADDR = '0;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: combinational operand read mux with optional write-back forwarding
// Ports: rst (async reset, forces 0), re/raddr (read request), we/waddr/wdata (write-back
// being committed this cycle), stored (array value at raddr), rdata (operand out).
// Build option: REGFILE_BYPASS_EN enables same-cycle forwarding of wdata.
module regfile_rd_port
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = REG_BUS,
  parameter int ADDR_W = REG_ADDR_BUS
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] stored,
  output logic [DATA_W-1:0] rdata
);
  logic hit;
`ifdef REGFILE_BYPASS_EN
  assign hit = (we == WRITE_ENABLE) && (waddr == raddr);
`else
  logic unused;
  assign unused = ^{we, waddr, wdata};
  assign hit = 1'b0;
`endif
  always_comb begin
    rdata = (rst == RST_ENABLE) ? ZERO_WORD[DATA_W-1:0] :
            (raddr == '0) ? ZERO_WORD[DATA_W-1:0] :
            (re == READ_DISABLE) ? ZERO_WORD[DATA_W-1:0] :
            hit ? wdata : stored;
  end
endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: architectural register file fed by the MEM/WB write-back interface
// Ports: clk, rst (async, active-high); we/waddr/wdata write-back; re1/raddr1/rdata1 and
// re2/raddr2/rdata2 operand reads; dbg_raddr/dbg_rdata unbypassed debug read;
// wb_cnt counts committed (non-r0) writes, wrapping at 2^32.
// Build option: REGFILE_BYPASS_EN enables write-to-read forwarding on ports 1 and 2.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = REG_BUS,
  parameter int ADDR_W = REG_ADDR_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [31:0]       wb_cnt
);
  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic [31:0] cnt;
  logic wr;
  // r0 writes are dropped entirely, so they neither store nor count
  assign wr = (we != WRITE_DISABLE) && (waddr != NOP_REG_ADDR[ADDR_W-1:0]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      regs <= '{default: '0};
      cnt <= '0;
    end else if (wr) begin
      regs[waddr] <= wdata;
      cnt <= cnt + 32'd1;
    end
  end
  assign wb_cnt = cnt;
  assign dbg_rdata = (rst == RST_ENABLE || dbg_raddr == '0) ? ZERO_WORD[DATA_W-1:0] : regs[dbg_raddr];
  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .rst(rst), .re(re1), .raddr(raddr1), .we(we), .waddr(waddr), .wdata(wdata),
    .stored(regs[raddr1]), .rdata(rdata1)
  );
  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .rst(rst), .re(re2), .raddr(raddr2), .we(we), .waddr(waddr), .wdata(wdata),
    .stored(regs[raddr2]), .rdata(rdata2)
  );
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: scoreboard bench for regfile_wb (directed cases plus a modelled random run)
module tb_regfile_wb;
  logic clk = 0, rst = 1, we = 0, re1 = 0, re2 = 0;
  logic [4:0] waddr = 0, raddr1 = 0, raddr2 = 0, dbg_raddr = 0;
  logic [31:0] wdata = 0, rdata1, rdata2, dbg_rdata, wb_cnt;
  int total = 0, bad = 0;
  typedef struct {string tag; int sel; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  logic [31:0] m [32];
  logic [31:0] mcnt;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1;
`else
  localparam bit BYP = 0;
`endif
  regfile_wb dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .wb_cnt(wb_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    sb.push_back('{tag, sel, exp});
  endtask
  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, e.sel == 0 ? rdata1 : e.sel == 1 ? rdata2 : e.sel == 2 ? dbg_rdata : wb_cnt, e.exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1; waddr = a; wdata = d;
    tick();
    we = 0; waddr = 0; wdata = 0;
  endtask
  function automatic logic [31:0] rd(input logic e, input logic [4:0] a);
    return (a == 0 || !e) ? 32'h0 : (BYP && we && waddr == a) ? wdata : m[a];
  endfunction
  initial begin
    re1 = 1; re2 = 1; raddr1 = 5; raddr2 = 5; dbg_raddr = 5;
    push("rst_r1", 0, 0); push("rst_r2", 1, 0); push("rst_dbg", 2, 0); push("rst_cnt", 3, 0);
    drain();
    tick(); rst = 0;
    wr(5, 32'h1234_5678);
    push("pre_r5", 0, 32'h1234_5678); push("pre_cnt", 3, 1);
    drain();
    rst = 1;
    push("midrst_r1", 0, 0); push("midrst_dbg", 2, 0); push("midrst_cnt", 3, 0);
    drain();
    rst = 0;
    push("postrst_r5", 0, 0); push("postrst_dbg", 2, 0); push("postrst_cnt", 3, 0);
    drain();
    wr(3, 32'hDEAD_BEEF);
    re1 = 1; raddr1 = 3; re2 = 0; raddr2 = 3; dbg_raddr = 3;
    push("basic_r1", 0, 32'hDEAD_BEEF); push("basic_re2off", 1, 0);
    push("basic_dbg", 2, 32'hDEAD_BEEF); push("basic_cnt", 3, 1);
    drain();
    re2 = 1; raddr1 = 0; raddr2 = 0; dbg_raddr = 0;
    we = 1; waddr = 0; wdata = 32'hFFFF_FFFF;
    push("r0_wr_r1", 0, 0); push("r0_wr_r2", 1, 0); push("r0_wr_dbg", 2, 0);
    drain();
    tick(); we = 0; wdata = 0;
    push("r0_r1", 0, 0); push("r0_r2", 1, 0); push("r0_dbg", 2, 0); push("r0_cnt", 3, 1);
    drain();
    wr(7, 32'h1);
    raddr1 = 7; raddr2 = 7; dbg_raddr = 7;
    we = 1; waddr = 7; wdata = 32'h2;
    push("byp_r1", 0, BYP ? 32'h2 : 32'h1); push("byp_r2", 1, BYP ? 32'h2 : 32'h1);
    push("byp_dbg", 2, 32'h1); push("byp_cnt", 3, 2);
    drain();
    tick(); we = 0; waddr = 0; wdata = 0;
    push("byp_nx_r1", 0, 32'h2); push("byp_nx_r2", 1, 32'h2);
    push("byp_nx_dbg", 2, 32'h2); push("byp_nx_cnt", 3, 3);
    drain();
    repeat (3) tick();
    raddr1 = 3; raddr2 = 7; dbg_raddr = 5;
    push("bub_r3", 0, 32'hDEAD_BEEF); push("bub_r7", 1, 32'h2);
    push("bub_r5", 2, 0); push("bub_cnt", 3, 3);
    drain();
    rst = 1; #1; rst = 0;
    for (int i = 0; i < 32; i++) m[i] = 0;
    mcnt = 0;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1)); waddr = 5'($urandom_range(0, 7)); wdata = $urandom;
      re1 = 1'($urandom_range(0, 3) != 0); re2 = 1'($urandom_range(0, 3) != 0);
      raddr1 = 5'($urandom_range(0, 7)); raddr2 = 5'($urandom_range(0, 7));
      dbg_raddr = 5'($urandom_range(0, 7));
      push("rnd_r1", 0, rd(re1, raddr1)); push("rnd_r2", 1, rd(re2, raddr2));
      push("rnd_dbg", 2, dbg_raddr == 0 ? 32'h0 : m[dbg_raddr]); push("rnd_cnt", 3, mcnt);
      drain();
      tick();
      if (we && waddr != 0) begin
        m[waddr] = wdata;
        mcnt = mcnt + 1;
      end
    end
    we = 0; waddr = 0; wdata = 0; re1 = 1; raddr1 = 1;
    force dut.cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cnt;
    push("wrap_pre", 3, 32'hFFFF_FFFF);
    drain();
    wr(1, 32'hA5A5_0F0F);
    push("wrap_cnt", 3, 0); push("wrap_r1", 0, 32'hA5A5_0F0F);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
